alu_cmd_queue: RTL and testbench

Command buffer directly upstream of new_alu. Accepts ALU commands (op, A, B) from a producer over a valid/ready handshake and stores them in a DEPTH-entry FIFO. Issues one command per cycle into registered outputs that drive new_alu's i_op/i_arg_A/i_arg_B, honouring a downstream stall. Filters op codes new_alu does not implement.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_cmd_fifo_mem.sv | 72 +++++++
 rtl/alu_cmd_queue.sv | 104 ++++++++++
 tb/tb_alu_cmd_queue.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for new_alu and its command queue: widths, op codes, command record.
package alu_pkg;

   localparam int unsigned ALU_N = 4;
   localparam int unsigned ALU_M = 8;
   localparam int unsigned ALU_K = 8;

   localparam logic [ALU_N-1:0] OP_SHR_NOTB  = 4'b0000;
   localparam logic [ALU_N-1:0] OP_SHL       = 4'b0001;
   localparam logic [ALU_N-1:0] OP_ADD       = 4'b0010;
   localparam logic [ALU_N-1:0] OP_SUB       = 4'b0011;
   localparam logic [ALU_N-1:0] OP_AND       = 4'b0100;
   localparam logic [ALU_N-1:0] OP_OR        = 4'b0101;
   localparam logic [ALU_N-1:0] OP_XOR       = 4'b0110;
   localparam logic [ALU_N-1:0] OP_NOT_A     = 4'b0111;
   localparam logic [ALU_N-1:0] OP_MUL_LO    = 4'b1000;
   localparam logic [ALU_N-1:0] OP_MUL_HI    = 4'b1001;
   localparam logic [ALU_N-1:0] OP_ABS_A     = 4'b1010;
   localparam logic [ALU_N-1:0] OP_NOT_ABS_B = 4'b1011;
   localparam logic [ALU_N-1:0] OP_MAX       = OP_NOT_ABS_B;

   typedef struct packed {
      logic [ALU_N-1:0] op;
      logic [ALU_M-1:0] arg_A;
      logic [ALU_M-1:0] arg_B;
   } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo_mem.sv
// DEPTH-entry command storage with separate occupancy count and synchronous flush.
module alu_cmd_fifo_mem
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type cmd_t = alu_cmd_t
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  cmd_t                   wdata_i,
   output cmd_t                   rdata_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FullCount = DEPTH[PW:0];

   cmd_t            mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW:0]     count_q, count_d;
   logic            do_push, do_pop;

   assign full_o  = (count_q == FullCount);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push_i & ~full_o & ~flush_i;
      do_pop   = pop_i & ~empty_o & ~flush_i;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers wrap naturally since DEPTH is a power of two.
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/alu_cmd_queue.sv
// Command buffer feeding new_alu: handshake, illegal-op filter, stall-aware issue register.
// Define ALU_CMD_QUEUE_BYPASS_EN to let a command skip storage when the queue is empty.
module alu_cmd_queue
   import alu_pkg::*;
#(
   parameter int unsigned     N      = ALU_N,
   parameter int unsigned     M      = ALU_M,
   parameter int unsigned     DEPTH  = 4,
   parameter logic [N-1:0]    OP_MAX = alu_pkg::OP_MAX
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [N-1:0]           i_op,
   input  logic [M-1:0]           i_arg_A,
   input  logic [M-1:0]           i_arg_B,
   input  logic                   i_stall,
   input  logic                   i_flush,
   output logic [N-1:0]           o_op,
   output logic [M-1:0]           o_arg_A,
   output logic [M-1:0]           o_arg_B,
   output logic                   o_issue,
   output logic                   o_illegal,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_empty
);

   typedef struct packed {
      logic [N-1:0] op;
      logic [M-1:0] arg_A;
      logic [M-1:0] arg_B;
   } cmd_t;

   cmd_t         in_cmd, head_cmd;
   logic         full, empty;
   logic         accept, legal, push, pop, bypass;
   logic [N-1:0] op_q;
   logic [M-1:0] arg_a_q, arg_b_q;
   logic         issue_q, illegal_q;

   assign in_cmd = '{op: i_op, arg_A: i_arg_A, arg_B: i_arg_B};

   // Ready depends only on occupancy, so a full queue never refills on the pop edge.
   assign o_ready = ~full & ~i_reset;

   always_comb begin
      accept = i_valid & o_ready;
      legal  = (i_op <= OP_MAX);
`ifdef ALU_CMD_QUEUE_BYPASS_EN
      bypass = empty & accept & legal & ~i_stall & ~i_flush;
`else
      bypass = 1'b0;
`endif
      push   = accept & legal & ~i_flush & ~bypass;
      pop    = ~empty & ~i_stall & ~i_flush;
   end

   alu_cmd_fifo_mem #(
      .DEPTH (DEPTH),
      .cmd_t (cmd_t)
   ) u_fifo (
      .clk_i   (i_clk),
      .reset_i (i_reset),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (i_flush),
      .wdata_i (in_cmd),
      .rdata_o (head_cmd),
      .count_o (o_count),
      .full_o  (full),
      .empty_o (empty)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         op_q      <= '0;
         arg_a_q   <= '0;
         arg_b_q   <= '0;
         issue_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         issue_q   <= pop | bypass;
         illegal_q <= accept & ~legal;
         if (bypass) begin
            op_q    <= in_cmd.op;
            arg_a_q <= in_cmd.arg_A;
            arg_b_q <= in_cmd.arg_B;
         end else if (pop) begin
            op_q    <= head_cmd.op;
            arg_a_q <= head_cmd.arg_A;
            arg_b_q <= head_cmd.arg_B;
         end
      end
   end

   assign o_op      = op_q;
   assign o_arg_A   = arg_a_q;
   assign o_arg_B   = arg_b_q;
   assign o_issue   = issue_q;
   assign o_illegal = illegal_q;
   assign o_empty   = empty;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue; expectations are hand-computed per scenario.
module tb_alu_cmd_queue;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic       i_valid;
   logic       o_ready;
   logic [3:0] i_op;
   logic [7:0] i_arg_A;
   logic [7:0] i_arg_B;
   logic       i_stall;
   logic       i_flush;
   logic [3:0] o_op;
   logic [7:0] o_arg_A;
   logic [7:0] o_arg_B;
   logic       o_issue;
   logic       o_illegal;
   logic [2:0] o_count;
   logic       o_empty;

   int n_checks = 0;
   int n_errors = 0;

   alu_cmd_queue u_dut (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_op      (i_op),
      .i_arg_A   (i_arg_A),
      .i_arg_B   (i_arg_B),
      .i_stall   (i_stall),
      .i_flush   (i_flush),
      .o_op      (o_op),
      .o_arg_A   (o_arg_A),
      .o_arg_B   (o_arg_B),
      .o_issue   (o_issue),
      .o_illegal (o_illegal),
      .o_count   (o_count),
      .o_empty   (o_empty)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and land 1 time unit after it.
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b);
      i_valid = v;
      i_op    = op;
      i_arg_A = a;
      i_arg_B = b;
   endtask

   initial begin
      i_reset = 1'b1;
      i_stall = 1'b0;
      i_flush = 1'b0;
      drive(1'b0, 4'h0, 8'h00, 8'h00);
      #3;
      check("rst_ready", 32'(o_ready), 32'd0);
      check("rst_count", 32'(o_count), 32'd0);
      check("rst_empty", 32'(o_empty), 32'd1);
      check("rst_issue", 32'(o_issue), 32'd0);
      check("rst_illegal", 32'(o_illegal), 32'd0);
      check("rst_op", 32'(o_op), 32'd0);
      step();
      i_reset = 1'b0;
      #1;
      check("post_rst_ready", 32'(o_ready), 32'd1);

      // Single command, no stall
      drive(1'b1, 4'b0001, 8'h02, 8'hFC);
      step();
      drive(1'b0, 4'h0, 8'h00, 8'h00);
`ifdef ALU_CMD_QUEUE_BYPASS_EN
      check("t1_bypass_issue", 32'(o_issue), 32'd1);
      check("t1_bypass_count", 32'(o_count), 32'd0);
`else
      check("t1_e0_issue", 32'(o_issue), 32'd0);
      check("t1_e0_count", 32'(o_count), 32'd1);
      step();
      check("t1_issue", 32'(o_issue), 32'd1);
`endif
      check("t1_op", 32'(o_op), 32'h1);
      check("t1_A", 32'(o_arg_A), 32'h02);
      check("t1_B", 32'(o_arg_B), 32'hFC);
      check("t1_empty", 32'(o_empty), 32'd1);
      step();
      check("t1_idle_issue", 32'(o_issue), 32'd0);
      check("t1_hold_op", 32'(o_op), 32'h1);

      // Fill under stall: fifth attempt sees o_ready low
      i_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 4'(i + 1), 8'h10 + 8'(i), 8'h20 + 8'(i));
         check("t2_ready", 32'(o_ready), (i < 4) ? 32'd1 : 32'd0);
         step();
         check("t2_count", 32'(o_count), (i < 4) ? 32'(i + 1) : 32'd4);
         check("t2_no_issue", 32'(o_issue), 32'd0);
      end
      drive(1'b0, 4'h0, 8'h00, 8'h00);
      i_stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t2_issue", 32'(o_issue), 32'd1);
         check("t2_op", 32'(o_op), 32'(i + 1));
         check("t2_A", 32'(o_arg_A), 32'h10 + 32'(i));
         check("t2_B", 32'(o_arg_B), 32'h20 + 32'(i));
         check("t2_drain_count", 32'(o_count), 32'(3 - i));
      end
      check("t2_empty", 32'(o_empty), 32'd1);
      step();
      check("t2_idle", 32'(o_issue), 32'd0);

      // Illegal op is accepted and dropped
      drive(1'b1, 4'b1100, 8'h11, 8'h22);
      check("t3_ready", 32'(o_ready), 32'd1);
      step();
      check("t3_illegal", 32'(o_illegal), 32'd1);
      check("t3_count", 32'(o_count), 32'd0);
      check("t3_no_issue", 32'(o_issue), 32'd0);
      drive(1'b1, 4'b0101, 8'h33, 8'h44);
      step();
      drive(1'b0, 4'h0, 8'h00, 8'h00);
      check("t3_illegal_pulse", 32'(o_illegal), 32'd0);
`ifndef ALU_CMD_QUEUE_BYPASS_EN
      check("t3_legal_count", 32'(o_count), 32'd1);
      step();
`endif
      check("t3_legal_issue", 32'(o_issue), 32'd1);
      check("t3_legal_op", 32'(o_op), 32'h5);
      check("t3_legal_A", 32'(o_arg_A), 32'h33);
      step();

      // Simultaneous push/pop from count 2
      i_stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 4'(i + 1), 8'h50 + 8'(i), 8'hA0 + 8'(i));
         step();
      end
      check("t4_prefill", 32'(o_count), 32'd2);
      i_stall = 1'b0;
      for (int i = 2; i < 5; i++) begin
         drive(1'b1, 4'(i + 1), 8'h50 + 8'(i), 8'hA0 + 8'(i));
         step();
         check("t4_count", 32'(o_count), 32'd2);
         check("t4_issue", 32'(o_issue), 32'd1);
         check("t4_op", 32'(o_op), 32'(i - 1));
         check("t4_A", 32'(o_arg_A), 32'h50 + 32'(i - 2));
      end
      drive(1'b0, 4'h0, 8'h00, 8'h00);
      for (int i = 3; i < 5; i++) begin
         step();
         check("t4_drain_op", 32'(o_op), 32'(i + 1));
         check("t4_drain_B", 32'(o_arg_B), 32'hA0 + 32'(i));
      end
      check("t4_empty", 32'(o_empty), 32'd1);

      // Flush at count 3 with a concurrent push
      i_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'(i + 7), 8'h60 + 8'(i), 8'h70 + 8'(i));
         step();
      end
      check("t5_prefill", 32'(o_count), 32'd3);
      i_stall = 1'b0;
      i_flush = 1'b1;
      drive(1'b1, 4'hA, 8'h77, 8'h88);
      check("t5_ready", 32'(o_ready), 32'd1);
      step();
      i_flush = 1'b0;
      drive(1'b0, 4'h0, 8'h00, 8'h00);
      check("t5_count", 32'(o_count), 32'd0);
      check("t5_issue", 32'(o_issue), 32'd0);
      check("t5_hold_op", 32'(o_op), 32'h5);
      check("t5_hold_A", 32'(o_arg_A), 32'h54);
      check("t5_hold_B", 32'(o_arg_B), 32'hA4);
      for (int i = 0; i < 2; i++) begin
         step();
         check("t5_never_issues", 32'(o_issue), 32'd0);
         check("t5_still_op", 32'(o_op), 32'h5);
      end

      // Async reset mid-stream
      i_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'(i + 1), 8'h90 + 8'(i), 8'hC0 + 8'(i));
         step();
      end
      drive(1'b0, 4'h0, 8'h00, 8'h00);
      i_stall = 1'b0;
      step();
      check("t6_pre_issue", 32'(o_issue), 32'd1);
      check("t6_pre_count", 32'(o_count), 32'd2);
      check("t6_pre_op", 32'(o_op), 32'h1);
      #2;
      i_reset = 1'b1;
      #1;
      check("t6_issue", 32'(o_issue), 32'd0);
      check("t6_count", 32'(o_count), 32'd0);
      check("t6_op", 32'(o_op), 32'd0);
      check("t6_A", 32'(o_arg_A), 32'd0);
      check("t6_B", 32'(o_arg_B), 32'd0);
      check("t6_ready", 32'(o_ready), 32'd0);
      step();
      check("t6_ready_held", 32'(o_ready), 32'd0);
      i_reset = 1'b0;
      #1;
      check("t6_ready_rel", 32'(o_ready), 32'd1);
      check("t6_empty_rel", 32'(o_empty), 32'd1);
      step();
      check("t6_no_issue", 32'(o_issue), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
